// File: rtl/wb_interconnect_nx.sv
// wb_interconnect_nx: single-master, N-slave Wishbone interconnect.
// It decodes the master address against base/mask pairs, with the lowest
// matching index winning. The selected slave is held for the whole
// transaction, and its data/ack/err are muxed back to the master.
// An unmapped access gets a one-cycle bus error. A slave that never answers
// is aborted by a watchdog. The first fault is latched in a sticky register.
module wb_interconnect_nx #(
    parameter int                       NUM_SLAVES     = 6,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0}},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [31:0]              m_adr_i,
    input  logic [31:0]              m_dat_i,
    output logic [31:0]              m_dat_o,
    input  logic                     m_we_i,
    input  logic [3:0]               m_sel_i,
    input  logic                     m_stb_i,
    input  logic                     m_cyc_i,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    input  logic [NUM_SLAVES*32-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    input  logic                     fault_clr_i,
    output logic                     fault_valid_o,
    output logic [1:0]               fault_code_o,
    output logic [31:0]              fault_adr_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_UNMAPPED  = 2'b01,
        FC_TIMEOUT   = 2'b10,
        FC_SLAVE_ERR = 2'b11
    } fault_code_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_valid_q, fault_valid_d;
    fault_code_e        fault_code_q, fault_code_d;
    logic [31:0]        fault_adr_q, fault_adr_d;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               fault_evt;
    fault_code_e        fault_evt_code;
    logic [31:0]        s_dat_arr [NUM_SLAVES];

    // Request qualifiers and payload go straight through to every slave.
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_we_o  = m_we_i;
    assign s_sel_o = m_sel_i;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_unpack
        assign s_dat_arr[g] = s_dat_i[32*g +: 32];
    end

    // Address decode: scan from the top so the lowest matching index is the last one written.
    // NOTE: every signal driven here is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    // Transaction FSM: next state, watchdog, fault events and all bus outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        fault_evt      = 1'b0;
        fault_evt_code = FC_NONE;
        m_ack_o        = 1'b0;
        m_err_o        = 1'b0;
        m_dat_o        = '0;
        s_stb_o        = '0;
        s_cyc_o        = '0;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        cnt_d   = '0;
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d        = ST_ERR;
                        fault_evt      = 1'b1;
                        fault_evt_code = FC_UNMAPPED;
                    end
                end
            end
            ST_ACTIVE: begin
                // Gating stb with cyc makes a master abort drop the slave strobe in the same cycle.
                s_stb_o[idx_q] = m_stb_i & m_cyc_i;
                s_cyc_o[idx_q] = m_cyc_i;
                m_dat_o        = s_dat_arr[idx_q];
                m_ack_o        = s_ack_i[idx_q];
                m_err_o        = s_err_i[idx_q];
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (s_ack_i[idx_q] || s_err_i[idx_q]) begin
                    state_d = ST_IDLE;
                    if (s_err_i[idx_q]) begin
                        fault_evt      = 1'b1;
                        fault_evt_code = FC_SLAVE_ERR;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LIMIT) begin
                        state_d        = ST_ERR;
                        fault_evt      = 1'b1;
                        fault_evt_code = FC_TIMEOUT;
                    end
                end
            end
            ST_ERR: begin
                m_err_o = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky fault register: the first fault wins, and a new fault beats a coincident clear.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_code_d  = fault_code_q;
        fault_adr_d   = fault_adr_q;
        if (fault_evt && (!fault_valid_q || fault_clr_i)) begin
            fault_valid_d = 1'b1;
            fault_code_d  = fault_evt_code;
            fault_adr_d   = m_adr_i;
        end else if (fault_clr_i) begin
            fault_valid_d = 1'b0;
            fault_code_d  = FC_NONE;
            fault_adr_d   = '0;
        end
    end

    // State, selected index, watchdog counter and fault register flops.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            fault_valid_q <= 1'b0;
            fault_code_q  <= FC_NONE;
            fault_adr_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            fault_valid_q <= fault_valid_d;
            fault_code_q  <= fault_code_d;
            fault_adr_q   <= fault_adr_d;
        end
    end

    assign fault_valid_o = fault_valid_q;
    assign fault_code_o  = fault_code_q;
    assign fault_adr_o   = fault_adr_q;

endmodule

// File: tb/tb_wb_interconnect_nx.sv
// Bench for wb_interconnect_nx: directed scenarios followed by randomized
// transactions. A transaction-level reference model predicts the target
// slave, the cycle of each response, the error cycles and the fault register.
module tb_wb_interconnect_nx;

    localparam int NS = 6;
    localparam int T  = 8;
    // Slave regions, listed slave5 .. slave0. Slaves 2 and 3 overlap at 0x0800_0xxx.
    localparam logic [NS*32-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h0800_0000,
                                         32'h0800_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_FF00, 32'hF000_0000, 32'hFF00_0000,
                                         32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_8000};

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_HANG = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     m_adr_i, m_dat_i, m_dat_o;
    logic            m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o;
    logic [3:0]      m_sel_i;
    logic [31:0]     s_adr_o, s_dat_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic [NS-1:0]   s_stb_o, s_cyc_o, s_ack_i, s_err_i;
    logic [NS*32-1:0] s_dat_i;
    logic            fault_clr_i, fault_valid_o;
    logic [1:0]      fault_code_o;
    logic [31:0]     fault_adr_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference fault register.
    bit          mf_valid;
    logic [1:0]  mf_code;
    logic [31:0] mf_adr;

    wb_interconnect_nx #(
        .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .fault_clr_i(fault_clr_i),
        .fault_valid_o(fault_valid_o), .fault_code_o(fault_code_o), .fault_adr_o(fault_adr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lowest-index region containing addr, or -1 when unmapped.
    function automatic int ref_target(input logic [31:0] addr);
        for (int i = 0; i < NS; i++)
            if ((addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    task automatic model_fault(input bit evt, input logic [1:0] code, input logic [31:0] adr, input bit clr);
        if (evt && (!mf_valid || clr)) begin
            mf_valid = 1'b1; mf_code = code; mf_adr = adr;
        end else if (clr) begin
            mf_valid = 1'b0; mf_code = 2'b00; mf_adr = '0;
        end
    endtask

    task automatic check_fault(input string tag);
        check({tag, "_fvalid"}, 32'(fault_valid_o), 32'(mf_valid));
        check({tag, "_fcode"},  32'(fault_code_o),  32'(mf_code));
        check({tag, "_fadr"},   fault_adr_o,        mf_adr);
    endtask

    task automatic check_bus(input string tag, input logic [NS-1:0] stb, input logic [NS-1:0] cyc,
                             input bit ack, input bit err);
        check({tag, "_stb"}, 32'(s_stb_o), 32'(stb));
        check({tag, "_cyc"}, 32'(s_cyc_o), 32'(cyc));
        check({tag, "_ack"}, 32'(m_ack_o), 32'(ack));
        check({tag, "_err"}, 32'(m_err_o), 32'(err));
        check_fault(tag);
    endtask

    task automatic randomize_slave_data();
        for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = $urandom;
    endtask

    // One cycle with the master idle, optionally pulsing fault clear.
    task automatic idle_cycle(input bit clr);
        @(posedge clk); #1;
        m_stb_i = 1'b0; m_cyc_i = 1'b0; fault_clr_i = clr;
        s_ack_i = '0; s_err_i = '0; randomize_slave_data();
        #1;
        check_bus("idle", '0, '0, 1'b0, 1'b0);
        check("idle_dat", m_dat_o, 32'h0);
        model_fault(1'b0, 2'b00, 32'h0, clr);
    endtask

    // One master transaction. The target slave answers with `kind` on its
    // (lat+1)-th strobed cycle. abort_k > 0 drops cyc in that ACTIVE cycle.
    task automatic run_txn(input logic [31:0] addr, input int kind, input int lat,
                           input int abort_k, input logic [31:0] rdata, input bit clr0);
        int t, resp, k;
        bit done;
        logic [NS-1:0] oh;
        logic [31:0] wdat;
        t    = ref_target(addr);
        resp = (kind == K_HANG) ? -1 : 1 + lat;
        oh   = '0;
        if (t >= 0) oh[t] = 1'b1;
        wdat = $urandom;
        // Decode cycle: request presented, nothing reaches the slaves yet.
        @(posedge clk); #1;
        m_adr_i = addr; m_dat_i = wdat; m_we_i = 1'($urandom); m_sel_i = 4'($urandom);
        m_stb_i = 1'b1; m_cyc_i = 1'b1; fault_clr_i = clr0;
        s_ack_i = '0; s_err_i = '0; randomize_slave_data();
        #1;
        check_bus("dec", '0, '0, 1'b0, 1'b0);
        check("dec_dat", m_dat_o, 32'h0);
        check("bcast_adr", s_adr_o, addr);
        check("bcast_dat", s_dat_o, wdat);
        check("bcast_we",  32'(s_we_o), 32'(m_we_i));
        check("bcast_sel", 32'(s_sel_o), 32'(m_sel_i));
        model_fault(t < 0, 2'b01, addr, clr0);
        k = 1; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            fault_clr_i = 1'b0; s_ack_i = '0; s_err_i = '0;
            randomize_slave_data();
            if (t >= 0) s_dat_i[32*t +: 32] = rdata;
            if (t < 0) begin
                #1;
                check_bus("unmapped_err", '0, '0, 1'b0, 1'b1);
                check("unmapped_dat", m_dat_o, 32'h0);
                done = 1'b1;
            end else if (k == abort_k) begin
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
                #1;
                check_bus("abort", '0, '0, 1'b0, 1'b0);
                done = 1'b1;
            end else if (k > T) begin
                #1;
                check_bus("timeout_err", '0, '0, 1'b0, 1'b1);
                check("timeout_dat", m_dat_o, 32'h0);
                done = 1'b1;
            end else begin
                if (k == resp && s_stb_o[t]) begin
                    s_ack_i[t] = (kind == K_ACK);
                    s_err_i[t] = (kind == K_ERR);
                end
                #1;
                check_bus("active", oh, oh, (k == resp) && (kind == K_ACK), (k == resp) && (kind == K_ERR));
                check("active_dat", m_dat_o, rdata);
                if (k == resp) begin
                    model_fault(kind == K_ERR, 2'b11, addr, 1'b0);
                    done = 1'b1;
                end else if (k == T) begin
                    model_fault(1'b1, 2'b10, addr, 1'b0);
                end
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, kind, lat, resp, lim, abort_k, gap;
        logic [31:0] addr;
        rst_n = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0; m_stb_i = 1'b0; m_cyc_i = 1'b0;
        s_dat_i = '0; s_ack_i = '0; s_err_i = '0; fault_clr_i = 1'b0;
        mf_valid = 1'b0; mf_code = 2'b00; mf_adr = '0;
        #1;
        check_bus("reset", '0, '0, 1'b0, 1'b0);
        check("reset_dat", m_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Slave0 read of 0x100, acked on its second strobed cycle.
        run_txn(32'h0000_0100, K_ACK, 1, 0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle(1'b0);
        // Unmapped access.
        run_txn(32'h0C00_0000, K_ACK, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0);
        check("unmapped_code", 32'(fault_code_o), 32'h1);
        check("unmapped_adr", fault_adr_o, 32'h0C00_0000);
        // Slave1 hangs while the earlier fault is still held, so the register keeps code 01.
        run_txn(32'h1000_0040, K_HANG, 0, 0, 32'h1234_5678, 1'b0);
        idle_cycle(1'b1);
        // With the register cleared, a hang now records a timeout.
        run_txn(32'h1000_0080, K_HANG, 0, 0, 32'h1111_2222, 1'b0);
        idle_cycle(1'b0);
        check("timeout_code", 32'(fault_code_o), 32'h2);
        check("timeout_adr", fault_adr_o, 32'h1000_0080);
        // Master abort mid-ACTIVE leaves the fault register untouched.
        run_txn(32'h0000_0200, K_ACK, 4, 2, 32'hCAFE_0001, 1'b0);
        idle_cycle(1'b0);
        // Overlapping slaves 2 and 3, back-to-back with a slave error.
        run_txn(32'h0800_0100, K_ACK, 0, 0, 32'hA5A5_0002, 1'b0);
        run_txn(32'h0800_0100, K_ERR, 2, 0, 32'h5A5A_0003, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, NS);
            if (r == NS) addr = $urandom;
            else         addr = BASE[32*r +: 32] | ($urandom & ~MASK[32*r +: 32]);
            kind = $urandom_range(0, 9);
            kind = (kind < 6) ? K_ACK : (kind < 8) ? K_ERR : K_HANG;
            lat  = $urandom_range(0, 5);
            resp = (kind == K_HANG) ? T + 1 : 1 + lat;
            lim  = ((resp < T) ? resp : T) - 1;
            abort_k = 0;
            if ($urandom_range(0, 9) == 0 && lim >= 1) abort_k = $urandom_range(1, lim);
            run_txn(addr, kind, lat, abort_k, $urandom, $urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 5) == 0);
        end

        // Make sure a fault is held, then reset in the middle of an ACTIVE transfer.
        idle_cycle(1'b0);
        run_txn(32'h0C00_0010, K_ACK, 0, 0, 32'h0, 1'b0);
        @(posedge clk); #1;
        m_adr_i = 32'h0000_0300; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        s_ack_i = '0; s_err_i = '0; fault_clr_i = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_stb", 32'(s_stb_o), 32'h1);
        rst_n = 1'b0;
        #1;
        mf_valid = 1'b0; mf_code = 2'b00; mf_adr = '0;
        check_bus("mid_reset", '0, '0, 1'b0, 1'b0);
        check("mid_reset_dat", m_dat_o, 32'h0);
        @(posedge clk); #1;
        m_stb_i = 1'b0; m_cyc_i = 1'b0; rst_n = 1'b1;
        // Load a first fault, then clear coincident with a new unmapped fault.
        run_txn(32'h0C00_0020, K_ACK, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0);
        run_txn(32'h0C00_0040, K_ACK, 0, 0, 32'h0, 1'b1);
        idle_cycle(1'b0);
        check("clr_vs_fault_valid", 32'(fault_valid_o), 32'h1);
        check("clr_vs_fault_code", 32'(fault_code_o), 32'h1);
        check("clr_vs_fault_adr", fault_adr_o, 32'h0C00_0040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
